ret_stack: RTL and testbench



---
 rtl/ret_stack.sv | 110 +++++++++++
 tb/tb_ret_stack.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ret_stack.sv
// Return-address stack and PC load controller (ret > call > jmp priority).
// Optional feature macro: RET_STACK_WRAP_EN (circular stack, call-while-full overwrites oldest).
module ret_stack #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic                  jmp,
  input  logic                  call,
  input  logic                  ret,
  input  logic [WIDTH-1:0]      target,
  input  logic                  clr_err,
  output logic                  ld,
  output logic [WIDTH-1:0]      addr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  unf,
  output logic                  err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      stack_q [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d, top_idx;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
  logic                  push_en;
  logic [WIDTH-1:0]      push_data;

  // The write pointer runs mod DEPTH, so the top entry always sits just below it.
  assign top_idx   = ptr_q - DEPTH_LOG2'(1);
  assign push_data = pc_in + WIDTH'(1);

  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign err   = err_q;

  always_comb begin
    ld      = 1'b0;
    addr    = '0;
    push_en = 1'b0;
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    err_d   = clr_err ? 1'b0 : err_q;

    if (ret) begin
      if (call) err_d = 1'b1;
      if (!empty) begin
        ld      = 1'b1;
        addr    = stack_q[top_idx];
        ptr_d   = top_idx;
        count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      ld   = 1'b1;
      addr = target;
      if (!full) begin
        push_en = 1'b1;
        ptr_d   = ptr_q + DEPTH_LOG2'(1);
        count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      end else begin
        ovf_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
        // Overwrite the oldest slot; count stays pinned at DEPTH.
        push_en = 1'b1;
        ptr_d   = ptr_q + DEPTH_LOG2'(1);
`else
        push_en = 1'b0;
`endif
      end
    end else if (jmp) begin
      ld   = 1'b1;
      addr = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  // Stack storage carries no reset; entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack: vector table through an expectation queue, plus async-reset sequence.
module tb_ret_stack;

  logic       clk, rst;
  logic [7:0] pc_in, target;
  logic       jmp, call, ret, clr_err;
  logic       ld, full, empty, ovf, unf, err;
  logic [7:0] addr;
  logic [3:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic       jmp, call, ret, clr;
    logic [7:0] pc, tgt;
    logic       ld;
    logic [7:0] addr;
    logic [3:0] cnt;
    logic       ovf, unf, err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  ret_stack #(.WIDTH(8), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .jmp(jmp), .call(call), .ret(ret),
    .target(target), .clr_err(clr_err), .ld(ld), .addr(addr), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic add(input logic j, input logic c, input logic r, input logic cl,
                     input logic [7:0] pc, input logic [7:0] tgt, input logic eld,
                     input logic [7:0] eaddr, input logic [3:0] ecnt,
                     input logic eovf, input logic eunf, input logic eerr);
    vec_t v;
    v.jmp = j; v.call = c; v.ret = r; v.clr = cl; v.pc = pc; v.tgt = tgt;
    v.ld = eld; v.addr = eaddr; v.cnt = ecnt; v.ovf = eovf; v.unf = eunf; v.err = eerr;
    vecs.push_back(v);
  endtask

  // Drive one request just after a rising edge and queue what it should produce.
  task automatic applyStimulus(input vec_t v);
    jmp = v.jmp; call = v.call; ret = v.ret; clr_err = v.clr;
    pc_in = v.pc; target = v.tgt;
    exp_q.push_back(v);
  endtask

  // Combinational load checked mid-cycle, registered state checked after the edge.
  task automatic checkOutput(input int idx);
    vec_t e;
    string tag;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("v%0d", idx);
    cmp({tag, "_ld"}, {7'b0, ld}, {7'b0, e.ld});
    cmp({tag, "_addr"}, addr, e.addr);
    @(posedge clk);
    #1;
    cmp({tag, "_count"}, {4'b0, count}, {4'b0, e.cnt});
    cmp({tag, "_full"}, {7'b0, full}, {7'b0, (e.cnt == 4'd8)});
    cmp({tag, "_empty"}, {7'b0, empty}, {7'b0, (e.cnt == 4'd0)});
    cmp({tag, "_ovf"}, {7'b0, ovf}, {7'b0, e.ovf});
    cmp({tag, "_unf"}, {7'b0, unf}, {7'b0, e.unf});
    cmp({tag, "_err"}, {7'b0, err}, {7'b0, e.err});
  endtask

  initial begin
    rst = 1'b1; jmp = 0; call = 0; ret = 0; clr_err = 0; pc_in = 0; target = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp("reset_count", {4'b0, count}, 8'h00);
    cmp("reset_empty", {7'b0, empty}, 8'h01);
    cmp("reset_flags", {5'b0, ovf, unf, err}, 8'h00);
    cmp("reset_ld", {7'b0, ld}, 8'h00);
    cmp("reset_addr", addr, 8'h00);

    //  j c r clr  pc     tgt    ld addr   cnt ovf unf err
    add(0,0,0,0, 8'h00, 8'h00, 0, 8'h00, 0, 0,0,0);
    add(0,1,0,0, 8'h10, 8'h40, 1, 8'h40, 1, 0,0,0);
    add(0,0,1,0, 8'h00, 8'h00, 1, 8'h11, 0, 0,0,0);
    add(1,0,0,0, 8'h00, 8'h55, 1, 8'h55, 0, 0,0,0);
    add(0,1,0,0, 8'h01, 8'h80, 1, 8'h80, 1, 0,0,0);
    add(0,1,0,0, 8'h02, 8'h81, 1, 8'h81, 2, 0,0,0);
    add(0,1,0,0, 8'h03, 8'h82, 1, 8'h82, 3, 0,0,0);
    add(0,0,1,0, 8'h00, 8'h00, 1, 8'h04, 2, 0,0,0);
    add(0,0,1,0, 8'h00, 8'h00, 1, 8'h03, 1, 0,0,0);
    add(0,0,1,0, 8'h00, 8'h00, 1, 8'h02, 0, 0,0,0);
    add(0,0,1,0, 8'h00, 8'h00, 0, 8'h00, 0, 0,1,0);
    add(0,0,0,0, 8'h00, 8'h00, 0, 8'h00, 0, 0,1,0);
    add(0,0,0,1, 8'h00, 8'h00, 0, 8'h00, 0, 0,0,0);
    add(0,0,1,1, 8'h00, 8'h00, 0, 8'h00, 0, 0,1,0);
    add(0,0,0,1, 8'h00, 8'h00, 0, 8'h00, 0, 0,0,0);
    add(0,1,0,0, 8'hFF, 8'h10, 1, 8'h10, 1, 0,0,0);
    add(1,0,1,0, 8'h00, 8'h99, 1, 8'h00, 0, 0,0,0);
    add(1,1,0,0, 8'h30, 8'h44, 1, 8'h44, 1, 0,0,0);
    add(0,0,1,0, 8'h00, 8'h00, 1, 8'h31, 0, 0,0,0);
    add(0,1,0,0, 8'h20, 8'h50, 1, 8'h50, 1, 0,0,0);
    add(0,1,1,0, 8'h77, 8'h66, 1, 8'h21, 0, 0,0,1);
    add(0,0,0,1, 8'h00, 8'h00, 0, 8'h00, 0, 0,0,0);
    for (int i = 0; i < 9; i++)
      add(0,1,0,0, 8'(i), 8'(8'h60 + i), 1, 8'(8'h60 + i),
          (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0, 0);
    for (int j = 0; j < 8; j++)
`ifdef RET_STACK_WRAP_EN
      add(0,0,1,0, 8'h00, 8'h00, 1, 8'(9 - j), 4'(7 - j), 1, 0, 0);
`else
      add(0,0,1,0, 8'h00, 8'h00, 1, 8'(8 - j), 4'(7 - j), 1, 0, 0);
`endif
    add(0,0,0,1, 8'h00, 8'h00, 0, 8'h00, 0, 0,0,0);
    add(0,1,0,0, 8'h01, 8'h90, 1, 8'h90, 1, 0,0,0);
    add(0,1,0,0, 8'h02, 8'h91, 1, 8'h91, 2, 0,0,0);
    add(0,1,0,0, 8'h03, 8'h92, 1, 8'h92, 3, 0,0,0);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkOutput(k);
    end

    // Asynchronous reset mid-cycle with a call still asserted.
    call = 1'b1; ret = 1'b0; jmp = 1'b0; clr_err = 1'b0; pc_in = 8'h40; target = 8'h70;
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_count", {4'b0, count}, 8'h00);
    cmp("async_rst_empty", {7'b0, empty}, 8'h01);
    call = 1'b0;
    #1;
    cmp("async_rst_ld", {7'b0, ld}, 8'h00);
    cmp("async_rst_addr", addr, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cmp("post_rst_count", {4'b0, count}, 8'h00);
    cmp("post_rst_flags", {5'b0, ovf, unf, err}, 8'h00);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
